// File: rtl/cap_channel_demux_pkg.sv
// Shared sizing and FSM encoding for the capacitor-to-channel return path.
package cap_channel_demux_pkg;

    localparam int WIDTH         = 8;
    localparam int CHANNEL_NUM   = 70;
    localparam int CAPACITOR_NUM = 128;
    localparam int IDX_W         = $clog2(CAPACITOR_NUM);

    typedef enum logic {
        SCAN  = 1'b0,
        READY = 1'b1
    } state_t;

endpackage

// File: rtl/cap_channel_demux_if.sv
// Bus bundle for cap_channel_demux: enable mask, lane readouts, channel data and status.
interface cap_channel_demux_if;
    import cap_channel_demux_pkg::*;

    logic [CAPACITOR_NUM-1:0]       sw;
    logic [WIDTH*CAPACITOR_NUM-1:0] data_in;
    logic [WIDTH*CHANNEL_NUM-1:0]   data_out;
    logic                           map_valid;
    logic                           map_err;
    logic                           busy;

    modport master (
        output sw, data_in,
        input  data_out, map_valid, map_err, busy
    );

    modport slave (
        input  sw, data_in,
        output data_out, map_valid, map_err, busy
    );

endinterface

// File: rtl/cap_map_scanner.sv
// Sequential scan of the enable mask building the channel->capacitor map and map status.
//  state | meaning
//  SCAN  | walking sw_q one capacitor per cycle, filling map entries in ascending order
//  READY | map complete, status held until sw changes
module cap_map_scanner
    import cap_channel_demux_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              restart,
    input  logic [CAPACITOR_NUM-1:0]          sw_q,
    output logic [CHANNEL_NUM-1:0][IDX_W-1:0] map,
    output logic [CHANNEL_NUM-1:0]            ent_vld,
    output logic                              ready,
    output logic                              busy,
    output logic                              map_valid,
    output logic                              map_err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CAPACITOR_NUM - 1);
    localparam logic [IDX_W-1:0] CH_MAX   = IDX_W'(CHANNEL_NUM);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [IDX_W-1:0] ch_cnt, ch_cnt_nxt;
    logic             ovf, ovf_nxt;
    logic             busy_nxt, valid_nxt, err_nxt;
    logic             wr_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SCAN;
            idx       <= '0;
            ch_cnt    <= '0;
            ovf       <= 1'b0;
            busy      <= 1'b0;
            map_valid <= 1'b0;
            map_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            ch_cnt    <= ch_cnt_nxt;
            ovf       <= ovf_nxt;
            busy      <= busy_nxt;
            map_valid <= valid_nxt;
            map_err   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        ch_cnt_nxt = ch_cnt;
        ovf_nxt    = ovf;
        busy_nxt   = busy;
        valid_nxt  = map_valid;
        err_nxt    = map_err;
        wr_en      = 1'b0;
        if (restart) begin
            state_nxt  = SCAN;
            idx_nxt    = '0;
            ch_cnt_nxt = '0;
            ovf_nxt    = 1'b0;
            busy_nxt   = 1'b1;
            valid_nxt  = 1'b0;
            err_nxt    = 1'b0;
        end else begin
            case (state)
                SCAN: begin
                    busy_nxt = 1'b1;
                    idx_nxt  = idx + 1'b1;
                    if (sw_q[idx]) begin
                        if (ch_cnt < CH_MAX) begin
                            wr_en      = 1'b1;
                            ch_cnt_nxt = ch_cnt + 1'b1;
                        end else begin
                            ovf_nxt = 1'b1;
                        end
                    end
                    // Status is decided on the final lane so its own contribution counts.
                    if (idx == LAST_IDX) begin
                        state_nxt = READY;
                        busy_nxt  = 1'b0;
                        valid_nxt = (ch_cnt_nxt == CH_MAX) && !ovf_nxt;
                        err_nxt   = !((ch_cnt_nxt == CH_MAX) && !ovf_nxt);
                    end
                end
                READY: begin
                    busy_nxt = 1'b0;
                end
                default: begin
                    state_nxt = SCAN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            map     <= '0;
            ent_vld <= '0;
        end else if (restart) begin
            ent_vld <= '0;
        end else if (wr_en) begin
            map[ch_cnt]     <= idx;
            ent_vld[ch_cnt] <= 1'b1;
        end
    end

    assign ready = (state == READY);

endmodule

// File: rtl/cap_channel_demux.sv
// Compacts enabled capacitor lanes onto output channels via a scanned map and registered gather.
// Optional CAP_DEMUX_HOLD_EN: data_out holds its last READY value while a rescan runs.
module cap_channel_demux
    import cap_channel_demux_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    cap_channel_demux_if.slave  bus
);

    logic [CAPACITOR_NUM-1:0]          sw_q;
    logic                              restart;
    logic [CHANNEL_NUM-1:0][IDX_W-1:0] map;
    logic [CHANNEL_NUM-1:0]            ent_vld;
    logic                              ready;
    logic                              busy;
    logic                              map_valid;
    logic                              map_err;
    logic [WIDTH-1:0]                  lane [CAPACITOR_NUM];
    logic [WIDTH*CHANNEL_NUM-1:0]      gather;
    logic [WIDTH*CHANNEL_NUM-1:0]      data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_q <= '0;
        end else begin
            sw_q <= bus.sw;
        end
    end

    assign restart = (bus.sw != sw_q);

    cap_map_scanner u_scanner (
        .clk       (clk),
        .rst       (rst),
        .restart   (restart),
        .sw_q      (sw_q),
        .map       (map),
        .ent_vld   (ent_vld),
        .ready     (ready),
        .busy      (busy),
        .map_valid (map_valid),
        .map_err   (map_err)
    );

    for (genvar i = 0; i < CAPACITOR_NUM; i++) begin : g_lane
        assign lane[i] = bus.data_in[i*WIDTH +: WIDTH];
    end

    always_comb begin
        gather = '0;
        for (int k = 0; k < CHANNEL_NUM; k++) begin
            gather[k*WIDTH +: WIDTH] = ent_vld[k] ? lane[map[k]] : '0;
        end
    end

    // A restart edge is treated as scan time: the map is being invalidated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else if (ready && !restart) begin
            data_q <= gather;
        end else begin
`ifdef CAP_DEMUX_HOLD_EN
            data_q <= data_q;
`else
            data_q <= '0;
`endif
        end
    end

    assign bus.data_out  = data_q;
    assign bus.busy      = busy;
    assign bus.map_valid = map_valid;
    assign bus.map_err   = map_err;

endmodule

// File: tb/tb_cap_channel_demux.sv
// Directed bench for cap_channel_demux: lane i carries value i, expected channel data built per test.
module tb_cap_channel_demux;
    import cap_channel_demux_pkg::*;

    localparam int DW = WIDTH*CHANNEL_NUM;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [DW-1:0] scan_dat;

    always #5 clk = ~clk;

    cap_channel_demux_if bus ();

    cap_channel_demux dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [CAPACITOR_NUM-1:0] rng(input int lo, input int hi);
        logic [CAPACITOR_NUM-1:0] m;
        m = '0;
        for (int i = lo; i < hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Channels below n0 carry k, then base1 onwards up to ntot channels, rest zero.
    function automatic logic [DW-1:0] mk(input int n0, input int base1, input int ntot);
        logic [DW-1:0] v;
        v = '0;
        for (int k = 0; k < CHANNEL_NUM; k++) begin
            if (k < n0)        v[k*WIDTH +: WIDTH] = WIDTH'(k);
            else if (k < ntot) v[k*WIDTH +: WIDTH] = WIDTH'(base1 + k - n0);
        end
        return v;
    endfunction

    task automatic run_scan(input string name, input logic [CAPACITOR_NUM-1:0] s,
                            input logic v, input logic [DW-1:0] expd);
        bus.sw = s;
        tick(1);
        chk({name, " busy_start"}, DW'(bus.busy), DW'(1));
        chk({name, " valid_start"}, DW'(bus.map_valid), DW'(0));
        chk({name, " err_start"}, DW'(bus.map_err), DW'(0));
        tick(127);
        chk({name, " busy_last"}, DW'(bus.busy), DW'(1));
        chk({name, " valid_early"}, DW'(bus.map_valid), DW'(0));
        chk({name, " data_scan"}, bus.data_out, scan_dat);
        tick(1);
        chk({name, " busy_done"}, DW'(bus.busy), DW'(0));
        chk({name, " map_valid"}, DW'(bus.map_valid), DW'(v));
        chk({name, " map_err"}, DW'(bus.map_err), DW'(!v));
        chk({name, " data_pre"}, bus.data_out, scan_dat);
        tick(1);
        chk({name, " data_out"}, bus.data_out, expd);
        chk({name, " valid_hold"}, DW'(bus.map_valid), DW'(v));
`ifdef CAP_DEMUX_HOLD_EN
        scan_dat = expd;
`endif
    endtask

    initial begin
        scan_dat = '0;
        bus.sw = rng(0, 70);
        bus.data_in = '0;
        for (int i = 0; i < CAPACITOR_NUM; i++) bus.data_in[i*WIDTH +: WIDTH] = WIDTH'(i);
        tick(2);
        chk("rst busy", DW'(bus.busy), DW'(0));
        chk("rst valid", DW'(bus.map_valid), DW'(0));
        chk("rst err", DW'(bus.map_err), DW'(0));
        chk("rst data", bus.data_out, '0);
        rst = 1'b0;

        run_scan("t1_lower70", rng(0, 70), 1'b1, mk(70, 0, 70));
        run_scan("t2_upper70", rng(58, 128), 1'b1, mk(0, 58, 70));
        run_scan("t3_lower69", rng(0, 69), 1'b0, mk(69, 0, 69));
        run_scan("t4_lower71", rng(0, 71), 1'b0, mk(70, 0, 70));

        bus.sw = rng(58, 128);
        tick(40);
        chk("t5 busy_c40", DW'(bus.busy), DW'(1));
        chk("t5 valid_c40", DW'(bus.map_valid), DW'(0));
        chk("t5 data_c40", bus.data_out, scan_dat);
        bus.sw = rng(0, 70);
        tick(60);
        chk("t5 busy_c100", DW'(bus.busy), DW'(1));
        chk("t5 valid_c100", DW'(bus.map_valid), DW'(0));
        chk("t5 err_c100", DW'(bus.map_err), DW'(0));
        chk("t5 data_c100", bus.data_out, scan_dat);
        run_scan("t5_split", rng(0, 35) | rng(64, 99), 1'b1, mk(35, 64, 70));

        bus.sw = rng(0, 70);
        tick(60);
        rst = 1'b1;
        #1;
        chk("t6 rst_busy", DW'(bus.busy), DW'(0));
        chk("t6 rst_valid", DW'(bus.map_valid), DW'(0));
        chk("t6 rst_err", DW'(bus.map_err), DW'(0));
        chk("t6 rst_data", bus.data_out, '0);
        tick(3);
        rst = 1'b0;
        scan_dat = '0;
        run_scan("t6_after_rst", rng(0, 70), 1'b1, mk(70, 0, 70));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
